// File: rtl/bbus_source_sel_pkg.sv
// rtl/bbus_source_sel_pkg.sv - shared select codes, state encoding and helpers for the B-bus selector
package bbus_source_sel_pkg;

    // Select codes driven by the control unit's B-select field
    localparam logic [3:0] BSEL_IDLE = 4'd0;
    localparam logic [3:0] BSEL_PC   = 4'd1;
    localparam logic [3:0] BSEL_SP   = 4'd2;
    localparam logic [3:0] BSEL_IR   = 4'd3;
    localparam logic [3:0] BSEL_MAR  = 4'd4;
    localparam logic [3:0] BSEL_MDR  = 4'd5;
    localparam logic [3:0] BSEL_R0   = 4'd6;
    localparam logic [3:0] BSEL_R1   = 4'd7;
    localparam logic [3:0] BSEL_R2   = 4'd8;
    localparam logic [3:0] BSEL_R3   = 4'd9;
    localparam logic [3:0] BSEL_R4   = 4'd10;
    localparam logic [3:0] BSEL_R5   = 4'd11;
    localparam logic [3:0] BSEL_MEM  = 4'd12;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } bbus_state_e;

    // Width of a counter that must be able to hold the value timeout
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/bbus_source_sel_wait_timer.sv
// rtl/bbus_source_sel_wait_timer.sv - clear/increment wait counter with terminal count at MEM_TIMEOUT-1
module bbus_wait_timer
    import bbus_source_sel_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = cnt_width(MEM_TIMEOUT)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q;

    assign tc_o = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

    // Clear wins over increment; the count saturates at terminal count instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && !tc_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/bbus_source_sel.sv
// rtl/bbus_source_sel.sv - registered B-bus source selector with memory wait and sticky errors
module bbus_source_sel
    import bbus_source_sel_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int NUM_SRC     = 11,
    parameter int MEM_W       = 8,
    parameter int MEM_CODE    = NUM_SRC + 1,
    parameter int SEL_W       = 4,
    parameter int MEM_SEXT    = 0,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sel_valid,
    input  logic [SEL_W-1:0]          sel,
    output logic                      sel_ready,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [MEM_W-1:0]          mem_data,
    input  logic                      mem_ack,
    output logic [DATA_W-1:0]         bus_data,
    output logic                      bus_valid,
    output logic                      err_illegal,
    output logic                      err_timeout,
    input  logic                      err_clr
);

    bbus_state_e       state_q;
    logic [DATA_W-1:0] bus_data_q;
    logic              bus_valid_q;
    logic              err_illegal_q;
    logic              err_timeout_q;

    logic [DATA_W-1:0] reg_mux;
    logic              is_reg;
    logic              is_mem;
    logic              is_nop;
    logic              accept;
    logic [DATA_W-1:0] mem_ext;
    logic              tmr_clr;
    logic              tmr_inc;
    logic              tmr_tc;

    assign sel_ready   = (state_q == ST_IDLE);
    assign bus_data    = bus_data_q;
    assign bus_valid   = bus_valid_q;
    assign err_illegal = err_illegal_q;
    assign err_timeout = err_timeout_q;

    assign accept = sel_ready && sel_valid;
    assign is_mem = (sel == SEL_W'(MEM_CODE));
    assign is_nop = (sel == SEL_W'(BSEL_IDLE));

    // Register-source decode and slice mux; code k picks slice k-1
    always_comb begin
        is_reg  = 1'b0;
        reg_mux = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (sel == SEL_W'(k + 1)) begin
                is_reg  = 1'b1;
                reg_mux = src_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Widen memory data to the bus, zero- or sign-filling the upper bits
    generate
        if (MEM_W < DATA_W) begin : g_ext
            assign mem_ext = (MEM_SEXT != 0)
                           ? {{(DATA_W-MEM_W){mem_data[MEM_W-1]}}, mem_data}
                           : {{(DATA_W-MEM_W){1'b0}}, mem_data};
        end else begin : g_noext
            assign mem_ext = mem_data;
        end
    endgenerate

    assign tmr_clr = accept && is_mem;
    assign tmr_inc = (state_q == ST_WAIT_MEM) && !mem_ack;

    bbus_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (cnt_width(MEM_TIMEOUT))
    ) u_wait_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (tmr_clr),
        .inc_i (tmr_inc),
        .tc_o  (tmr_tc)
    );

    // Selector FSM; flag sets are written after the clear so a same-edge set wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            bus_data_q    <= '0;
            bus_valid_q   <= 1'b0;
            err_illegal_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            bus_valid_q <= 1'b0;
            if (err_clr) begin
                err_illegal_q <= 1'b0;
                err_timeout_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (sel_valid) begin
                        if (is_nop) begin
                            bus_data_q <= bus_data_q;
                        end else if (is_reg) begin
                            bus_data_q  <= reg_mux;
                            bus_valid_q <= 1'b1;
                        end else if (is_mem) begin
                            state_q <= ST_WAIT_MEM;
                        end else begin
                            err_illegal_q <= 1'b1;
                        end
                    end
                end
                ST_WAIT_MEM: begin
                    if (mem_ack) begin
                        bus_data_q  <= mem_ext;
                        bus_valid_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else if (tmr_tc) begin
                        bus_data_q    <= '0;
                        bus_valid_q   <= 1'b1;
                        err_timeout_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bbus_source_sel.sv
// tb/tb_bbus_source_sel.sv - self-checking bench for bbus_source_sel (zero- and sign-extending instances)
module tb_bbus_source_sel;

    localparam int DATA_W  = 16;
    localparam int NUM_SRC = 11;
    localparam int TMO     = 15;
    localparam int MCODE   = 12;

    logic                      clk;
    logic                      rst_n;
    logic                      sel_valid;
    logic [3:0]                sel;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [7:0]                mem_data;
    logic                      mem_ack;
    logic                      err_clr;

    logic                      ready0, ready1;
    logic [DATA_W-1:0]         bus0, bus1;
    logic                      valid0, valid1;
    logic                      ill0, ill1;
    logic                      to0, to1;

    bbus_source_sel #(.MEM_SEXT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .sel_valid(sel_valid), .sel(sel), .sel_ready(ready0),
        .src_data(src_data), .mem_data(mem_data), .mem_ack(mem_ack), .bus_data(bus0),
        .bus_valid(valid0), .err_illegal(ill0), .err_timeout(to0), .err_clr(err_clr)
    );

    bbus_source_sel #(.MEM_SEXT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sel_valid(sel_valid), .sel(sel), .sel_ready(ready1),
        .src_data(src_data), .mem_data(mem_data), .mem_ack(mem_ack), .bus_data(bus1),
        .bus_valid(valid1), .err_illegal(ill1), .err_timeout(to1), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] src_arr [NUM_SRC];

    // Reference: pending read tracked as "cycles waited so far"
    bit          m_busy;
    int          m_waited;
    logic [15:0] m_bus0, m_bus1;
    bit          m_valid, m_ill, m_to;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_waited = 0; m_bus0 = '0; m_bus1 = '0;
        m_valid = 0; m_ill = 0; m_to = 0;
    endtask

    task automatic model_step();
        bit set_ill, set_to;
        set_ill = 0; set_to = 0;
        m_valid = 0;
        if (!m_busy) begin
            if (sel_valid) begin
                if (sel == 0) begin
                end else if (sel <= NUM_SRC) begin
                    m_bus0 = src_arr[sel-1]; m_bus1 = src_arr[sel-1]; m_valid = 1;
                end else if (sel == MCODE) begin
                    m_busy = 1; m_waited = 0;
                end else begin
                    set_ill = 1;
                end
            end
        end else begin
            m_waited++;
            if (mem_ack) begin
                m_bus0 = {8'h00, mem_data};
                m_bus1 = {{8{mem_data[7]}}, mem_data};
                m_valid = 1; m_busy = 0;
            end else if (m_waited == TMO) begin
                m_bus0 = '0; m_bus1 = '0; m_valid = 1; set_to = 1; m_busy = 0;
            end
        end
        m_ill = (m_ill && !err_clr) || set_ill;
        m_to  = (m_to  && !err_clr) || set_to;
    endtask

    // Drive one cycle of inputs, advance the reference, then sample after the edge
    task automatic apply(input logic sv, input logic [3:0] s, input logic ack,
                         input logic [7:0] md, input logic clr);
        sel_valid = sv; sel = s; mem_ack = ack; mem_data = md; err_clr = clr;
        for (int k = 0; k < NUM_SRC; k++) src_data[k*DATA_W +: DATA_W] = src_arr[k];
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model();
        chk("bus_data_zext", 32'(bus0), 32'(m_bus0));
        chk("bus_data_sext", 32'(bus1), 32'(m_bus1));
        chk("bus_valid", {30'd0, valid1, valid0}, {30'd0, m_valid, m_valid});
        chk("sel_ready", {30'd0, ready1, ready0}, {30'd0, !m_busy, !m_busy});
        chk("err_illegal", {30'd0, ill1, ill0}, {30'd0, m_ill, m_ill});
        chk("err_timeout", {30'd0, to1, to0}, {30'd0, m_to, m_to});
    endtask

    typedef struct {
        logic        sv;
        logic [3:0]  sel;
        logic        ack;
        logic [7:0]  md;
        logic        clr;
        logic [15:0] e_bus0;
        logic [15:0] e_bus1;
        logic        e_valid;
        logic        e_ready;
        logic        e_ill;
        logic        e_to;
    } vec_t;

    vec_t tbl [15];

    initial begin
        rst_n = 1'b0; sel_valid = 0; sel = 0; mem_ack = 0; mem_data = 0; err_clr = 0;
        for (int k = 0; k < NUM_SRC; k++) src_arr[k] = 16'(16'h0101 * (k + 1));
        src_arr[0]  = 16'h1234;
        src_arr[2]  = 16'h3333;
        src_arr[9]  = 16'hAAAA;
        src_arr[10] = 16'hBBBB;
        for (int k = 0; k < NUM_SRC; k++) src_data[k*DATA_W +: DATA_W] = src_arr[k];
        model_reset();

        tbl[0]  = '{1'b1, 4'd1,  1'b0, 8'h00, 1'b0, 16'h1234, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 4'd1,  1'b0, 8'h00, 1'b0, 16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 4'd3,  1'b0, 8'h00, 1'b0, 16'h3333, 16'h3333, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 4'd10, 1'b0, 8'h00, 1'b0, 16'hAAAA, 16'hAAAA, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 4'd11, 1'b0, 8'h00, 1'b0, 16'hBBBB, 16'hBBBB, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 4'd0,  1'b0, 8'h00, 1'b0, 16'hBBBB, 16'hBBBB, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 4'd12, 1'b0, 8'h00, 1'b0, 16'hBBBB, 16'hBBBB, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 4'd1,  1'b0, 8'h00, 1'b0, 16'hBBBB, 16'hBBBB, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 4'd14, 1'b0, 8'h00, 1'b0, 16'hBBBB, 16'hBBBB, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 4'd0,  1'b1, 8'hA5, 1'b0, 16'h00A5, 16'hFFA5, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 4'd0,  1'b1, 8'h77, 1'b0, 16'h00A5, 16'hFFA5, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 4'd14, 1'b0, 8'h00, 1'b0, 16'h00A5, 16'hFFA5, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 4'd15, 1'b0, 8'h00, 1'b1, 16'h00A5, 16'hFFA5, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 4'd0,  1'b0, 8'h00, 1'b1, 16'h00A5, 16'hFFA5, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 4'd0,  1'b0, 8'h00, 1'b0, 16'h00A5, 16'hFFA5, 1'b0, 1'b1, 1'b0, 1'b0};

        #12;
        chk("rst_bus_data", 32'(bus0), 32'd0);
        chk("rst_bus_valid", 32'(valid0), 32'd0);
        chk("rst_sel_ready", 32'(ready0), 32'd1);
        chk("rst_flags", {30'd0, ill0, to0}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            apply(tbl[i].sv, tbl[i].sel, tbl[i].ack, tbl[i].md, tbl[i].clr);
            chk($sformatf("vec%0d_bus_zext", i), 32'(bus0), 32'(tbl[i].e_bus0));
            chk($sformatf("vec%0d_bus_sext", i), 32'(bus1), 32'(tbl[i].e_bus1));
            chk($sformatf("vec%0d_valid", i), 32'(valid0), 32'(tbl[i].e_valid));
            chk($sformatf("vec%0d_ready", i), 32'(ready0), 32'(tbl[i].e_ready));
            chk($sformatf("vec%0d_ill", i), 32'(ill0), 32'(tbl[i].e_ill));
            chk($sformatf("vec%0d_to", i), 32'(to0), 32'(tbl[i].e_to));
        end

        // Timeout: no ack ever, completes on the 15th edge after accept
        apply(1, 4'd12, 0, 8'h00, 0);
        for (int j = 1; j < TMO; j++) begin
            apply(0, 4'd0, 0, 8'h00, 0);
            chk("tmo_wait_valid", 32'(valid0), 32'd0);
            chk("tmo_wait_ready", 32'(ready0), 32'd0);
        end
        apply(0, 4'd0, 0, 8'h00, 0);
        chk("tmo_bus", {bus1, bus0}, 32'd0);
        chk("tmo_valid", 32'(valid0), 32'd1);
        chk("tmo_flag", {30'd0, to1, to0}, 32'd3);
        chk("tmo_ready", 32'(ready0), 32'd1);
        apply(0, 4'd0, 0, 8'h00, 1);
        chk("tmo_clr", 32'(to0), 32'd0);

        // Ack on the final allowed cycle wins over the timeout
        apply(1, 4'd12, 0, 8'h00, 0);
        for (int j = 1; j < TMO; j++) apply(0, 4'd0, 0, 8'h00, 0);
        apply(0, 4'd0, 1, 8'h80, 0);
        chk("lastack_bus_zext", 32'(bus0), 32'h0080);
        chk("lastack_bus_sext", 32'(bus1), 32'hFF80);
        chk("lastack_valid", 32'(valid0), 32'd1);
        chk("lastack_no_tmo", {30'd0, to1, to0}, 32'd0);

        // Reset during WAIT_MEM aborts the read and clears flags
        apply(1, 4'd13, 0, 8'h00, 0);
        chk("pre_rst_ill", 32'(ill0), 32'd1);
        apply(1, 4'd12, 0, 8'h00, 0);
        chk("pre_rst_ready", 32'(ready0), 32'd0);
        rst_n = 1'b0;
        #2;
        chk("arst_ready", 32'(ready0), 32'd1);
        chk("arst_bus", {bus1, bus0}, 32'd0);
        chk("arst_flags", {28'd0, ill1, ill0, to1, to0}, 32'd0);
        rst_n = 1'b1;
        model_reset();
        #2;
        apply(0, 4'd0, 1, 8'h5A, 0);
        chk("post_rst_ack_valid", {30'd0, valid1, valid0}, 32'd0);
        chk("post_rst_ack_bus", 32'(bus0), 32'd0);

        // Randomized traffic against the reference
        for (int c = 0; c < 600; c++) begin
            logic [3:0] s;
            for (int k = 0; k < NUM_SRC; k++) src_arr[k] = 16'($urandom);
            s = ($urandom_range(0, 3) == 0) ? 4'(MCODE) : 4'($urandom_range(0, 15));
            apply(1'($urandom_range(0, 1)), s, ($urandom_range(0, 9) == 0),
                  8'($urandom), ($urandom_range(0, 7) == 0));
            chk_model();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
